ifetch_pipe: RTL

- Parametrised next-generation instruction fetch unit for the single-cycle/pipelined MIPS core.
- Owns the PC and drives a synchronous-read instruction ROM with a fixed 1-cycle read latency.
- Buffers fetched words in a small instruction queue and presents them to the decoder through a valid/ready handshake.
- Accepts a single redirect (branch/jump/jal/jr target resolved by the controller/ALU) that flushes all speculative work.

---
 rtl/ifetch_pkg.sv | 20 ++
 rtl/ifetch_queue.sv | 60 ++++++
 rtl/ifetch_pipe.sv | 111 +++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared constants, queue entry layout and width helper for the instruction fetch slice.
package ifetch_pkg;
  localparam int INSTR_W  = 32;
  localparam int PC_MAX_W = 32;
  localparam int PC_STEP  = 4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  // pc is stored at full width; narrower PC_W instances zero-extend into it.
  typedef struct packed {
    logic [INSTR_W-1:0]  instr;
    logic [PC_MAX_W-1:0] pc;
  } qentry_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/ifetch_queue.sv
// Flushable synchronous FIFO holding fetched instruction entries.
// Latency: a push is visible at head the following cycle; flush empties it in one cycle.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int AW   = clog2(DEPTH),
  localparam int CW   = clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != FULL_CNT) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/ifetch_pipe.sv
// Instruction fetch: owns the PC, drives a 1-cycle-latency ROM and queues words for decode.
// Latency: first out_valid 2 cycles after reset release, 3 after a redirect; 1 instr/cycle sustained.
// Backpressure: out_ready=0 fills the queue, then issue stalls with the pc held.
module ifetch_pipe
  import ifetch_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int              DEPTH     = 4,
  parameter int              ROM_AW    = 14
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_rd_en,
  output logic [ROM_AW-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [PC_W-1:0]    out_link
);
  localparam int              CW         = clog2(DEPTH + 1);
  localparam logic [CW:0]     DEPTH_L    = (CW + 1)'(DEPTH);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    inflight_pc;
  logic               inflight;
  logic               inflight_epoch;
  logic               epoch;
  logic               pop;
  logic               push;
  logic               issue;
  logic [CW-1:0]      count;
  logic [CW:0]        occupancy;
  logic               q_empty;
  qentry_t            q_in;
  qentry_t            q_head;
  logic [PC_W-1:0]    head_pc;
  logic [INSTR_W-1:0] hold_instr;
  logic [PC_W-1:0]    hold_pc;
  logic [PC_W-1:0]    hold_link;

  assign out_valid = !q_empty;
  assign pop       = out_valid && out_ready;

  // Reserve a queue slot for every outstanding ROM read so a response never overflows.
  assign occupancy  = (CW + 1)'(count) + (CW + 1)'(inflight) - (CW + 1)'(pop);
  assign issue      = !reset && !redirect_valid && (occupancy < DEPTH_L);
  assign imem_rd_en = issue;
  assign imem_addr  = pc[ROM_AW+1:2];

  assign push = inflight && (inflight_epoch == epoch);
  assign q_in = {imem_rdata, PC_MAX_W'(inflight_pc)};

  ifetch_queue #(
    .DEPTH (DEPTH),
    .W     ($bits(qentry_t))
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (q_in),
    .pop       (pop),
    .head      (q_head),
    .empty     (q_empty),
    .count     (count)
  );

  assign head_pc   = q_head.pc[PC_W-1:0];
  assign out_instr = q_empty ? hold_instr : q_head.instr;
  assign out_pc    = q_empty ? hold_pc : head_pc;
  assign out_link  = q_empty ? hold_link : head_pc + PC_W'(PC_STEP);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc             <= RESET_VEC;
      inflight       <= 1'b0;
      inflight_epoch <= 1'b0;
      inflight_pc    <= '0;
      epoch          <= 1'b0;
    end else begin
      inflight <= issue;
      if (redirect_valid) begin
        pc    <= redirect_target & ALIGN_MASK;
        epoch <= ~epoch;
      end else if (issue) begin
        pc             <= pc + PC_W'(PC_STEP);
        inflight_pc    <= pc;
        inflight_epoch <= epoch;
      end
    end
  end

  // Outputs keep the last presented instruction while the queue is empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_instr <= NOP_INSTR;
      hold_pc    <= '0;
      hold_link  <= '0;
    end else if (!q_empty) begin
      hold_instr <= q_head.instr;
      hold_pc    <= head_pc;
      hold_link  <= head_pc + PC_W'(PC_STEP);
    end
  end
endmodule
